// File: rtl/deser4.sv
// deser4 - framed serial-to-parallel converter feeding a WIDTH-bit register.
//
// A frame opens with a `start` pulse while idle, then collects WIDTH bits of
// `sdin`, one per cycle in which `en` is high. Once the last bit arrives, the
// finished word is copied to `q` and `ready` pulses for one cycle. `q` only
// ever shows complete words; it holds its value between frames.
//
// Ports
//   clk    in         rising-edge clock for all logic
//   reset  in         synchronous, active-high; sets every register to zero
//   start  in         begin a frame (only honoured while idle)
//   en     in         bit-valid qualifier for sdin while shifting
//   sdin   in         serial data bit
//   clear  in         synchronous frame abort; leaves q untouched
//   q      out [W]    last completed word (registered)
//   ready  out        one-cycle strobe: q was updated this cycle
//   busy   out        high while a frame is being collected
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no frame open; q holds the last word; waiting for start
// SHIFT | collecting bits into shreg; cnt = number of bits taken so far
module deser4 #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             en,
    input  logic             sdin,
    input  logic             clear,
    output logic [WIDTH-1:0] q,
    output logic             ready,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt;

    // shreg with the current sdin already folded in. On the last bit this
    // value goes straight to q, so the final bit never has to sit in shreg.
    always_comb begin
        shifted = shreg;
        if (MSB_FIRST)
            shifted = {shreg[WIDTH-2:0], sdin};
        else
            shifted = {sdin, shreg[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            q     <= '0;
            ready <= 1'b0;
            busy  <= 1'b0;
        end else begin
            // ready is a strobe; only the last-bit branch raises it.
            ready <= 1'b0;
            if (clear) begin
                // Abort outranks start, en and completion; q is preserved.
                state <= IDLE;
                shreg <= '0;
                cnt   <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            // sdin on the start edge is not part of the frame.
                            state <= SHIFT;
                            shreg <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        // start is ignored here: no restart mid-frame.
                        if (en) begin
                            if (cnt == LAST_IDX) begin
                                q     <= shifted;
                                ready <= 1'b1;
                                busy  <= 1'b0;
                                cnt   <= '0;
                                state <= IDLE;
                            end else begin
                                shreg <= shifted;
                                cnt   <= cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_deser4.sv
module tb_deser4;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         start;
    logic         en;
    logic         sdin;
    logic         clear;
    logic [W-1:0] q_m;
    logic         ready_m;
    logic         busy_m;
    logic [W-1:0] q_l;
    logic         ready_l;
    logic         busy_l;

    deser4 #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .start(start), .en(en), .sdin(sdin),
        .clear(clear), .q(q_m), .ready(ready_m), .busy(busy_m)
    );

    deser4 #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .start(start), .en(en), .sdin(sdin),
        .clear(clear), .q(q_l), .ready(ready_l), .busy(busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: a frame is just the list of accepted bits.
    bit           in_frame  = 1'b0;
    bit           bits[$];
    logic [W-1:0] exp_qm    = '0;
    logic [W-1:0] exp_ql    = '0;
    bit           exp_ready = 1'b0;
    bit           exp_busy  = 1'b0;
    bit           mon_on    = 1'b0;
    logic [W-1:0] sb_m[$];
    logic [W-1:0] sb_l[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs, then update the model for that edge.
    task automatic step(input bit rs, input bit st, input bit e, input bit d, input bit cl);
        logic [W-1:0] wm;
        logic [W-1:0] wl;
        @(negedge clk);
        reset = rs; start = st; en = e; sdin = d; clear = cl;
        @(posedge clk);
        mon_on    = 1'b1;
        exp_ready = 1'b0;
        if (rs) begin
            in_frame = 1'b0; bits.delete(); exp_qm = '0; exp_ql = '0;
            exp_busy = 1'b0; sb_m.delete(); sb_l.delete();
        end else if (cl) begin
            in_frame = 1'b0; bits.delete(); exp_busy = 1'b0;
        end else if (!in_frame) begin
            if (st) begin
                in_frame = 1'b1; bits.delete(); exp_busy = 1'b1;
            end
        end else if (e) begin
            bits.push_back(d);
            if (bits.size() == W) begin
                wm = '0; wl = '0;
                for (int i = 0; i < W; i++) begin
                    wm[W-1-i] = bits[i];
                    wl[i]     = bits[i];
                end
                exp_qm = wm; exp_ql = wl;
                sb_m.push_back(wm); sb_l.push_back(wl);
                exp_ready = 1'b1; exp_busy = 1'b0; in_frame = 1'b0;
                bits.delete();
            end
        end
    endtask

    task automatic frame(input logic [W-1:0] b);
        step(0, 1, 0, 0, 0);
        for (int i = W - 1; i >= 0; i--) step(0, 0, 1, b[i], 0);
    endtask

    // Monitor: per-cycle flag checks plus scoreboard pops on each ready.
    always @(negedge clk) begin
        if (mon_on) begin
            check("ready_msb", {3'b0, ready_m}, {3'b0, exp_ready});
            check("ready_lsb", {3'b0, ready_l}, {3'b0, exp_ready});
            check("busy_msb", {3'b0, busy_m}, {3'b0, exp_busy});
            check("busy_lsb", {3'b0, busy_l}, {3'b0, exp_busy});
            check("q_hold_msb", q_m, exp_qm);
            check("q_hold_lsb", q_l, exp_ql);
            if (ready_m) begin
                if (sb_m.size() == 0) check("sb_msb_empty", 4'd1, 4'd0);
                else check("sb_word_msb", q_m, sb_m.pop_front());
            end
            if (ready_l) begin
                if (sb_l.size() == 0) check("sb_lsb_empty", 4'd1, 4'd0);
                else check("sb_word_lsb", q_l, sb_l.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; en = 1'b0; sdin = 1'b0; clear = 1'b0;

        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        #1 check("reset_q", q_m, 4'b0000);
        step(0, 0, 0, 0, 0);

        frame(4'b1011);
        #1 check("msb_first", q_m, 4'b1011);
        check("lsb_first", q_l, 4'b1101);

        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 0);
        #1 check("gap_word", q_m, 4'b0110);
        check("gap_ready", {3'b0, ready_m}, 4'd1);

        frame(4'b1011);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 1);
        #1 check("clear_keeps_q", q_m, 4'b1011);
        check("clear_busy", {3'b0, busy_m}, 4'd0);
        frame(4'b0011);
        #1 check("after_clear", q_m, 4'b0011);

        step(0, 1, 0, 0, 0);
        for (int i = 0; i < W - 1; i++) step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 1);
        #1 check("clear_last_q", q_m, 4'b0011);
        check("clear_last_rdy", {3'b0, ready_m}, 4'd0);

        frame(4'b1111);
        #1 check("b2b_first", q_m, 4'b1111);
        frame(4'b0101);
        #1 check("b2b_second", q_m, 4'b0101);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        #1 check("midreset_q", q_m, 4'b0000);
        check("midreset_busy", {3'b0, busy_m}, 4'd0);

        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) < 7,
                 1'($urandom),
                 $urandom_range(0, 49) == 0);
        end
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("sb_drained", 4'(sb_m.size() + sb_l.size()), 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
